perip_bridge: RTL and testbench
===============================

// Module: perip_bridge
// PURPOSE
// - Responder end of the myCPU perip_* bus: decodes perip_addr, serves DRAM and the board MMIO registers.
// - Returns the raw, unextended 32-bit word; the CPU does sign/zero extension and byte/half merging.
// - Owns the LED, seven-segment, switch/key and cycle-timer registers.
// - Sits between myCPU and the external DRAM macro and board pins.
// PARAMETERS
// DRAM_BASE   32'h8010_0000  byte base of the DRAM window
// DRAM_AW     16             DRAM word-address bits; window = 4*2**DRAM_AW bytes
// TICK_DIV    50_000         cpu_clk cycles per timer increment (>=1)
// SCAN_DIV    1024           cpu_clk cycles per seven-segment digit step (>=1)
// PORTS
// cpu_clk      in   1   system clock
// cpu_rst      in   1   synchronous, active-high reset
// perip_addr   in   32  byte address from CPU
// perip_wen    in   1   write strobe, committed on the cpu_clk edge
// perip_mask   in   2   00 byte, 01 half, 11 word (access-size info only)
// perip_wdata  in   32  full merged word to write
// perip_rdata  out  32  raw word at addressed location (combinational)
// dram_addr    out  DRAM_AW  word address to DRAM
// dram_wen     out  1   DRAM write enable
// dram_wdata   out  32  DRAM write data (= perip_wdata)
// dram_rdata   in   32  DRAM combinational read data
// sw_i         in   24  board switches (asynchronous)
// key_i        in   5   board keys (asynchronous)
// led_o        out  24  LED register
// seg_an_o     out  8   digit enables, active-low, one-hot
// seg_cx_o     out  8   segments {dp,g..a}, active-low
// BEHAVIOUR
// - Map:
//   DRAM window -> DRAM.  0x8020_0000 SW (RO).  0x8020_0010 KEY (RO).
//   0x8020_0020 SEG (RW).  0x8020_0040 LED (RW).
//   0x8020_0050 CNT: read = count, write = ctrl {clear:bit1, run:bit0}.
//   Addr bits[1:0] are ignored for selection.
// - Unmapped accesses: reads return 0, writes are dropped.
// - Read path is combinational from the current perip_addr, also while perip_wen=1. The CPU merge needs the old word in the same cycle.
// - Writes take effect at the edge; a read in the next cycle returns the new value. perip_mask is not used for byte enables because wdata is pre-merged.
// - dram_wen = perip_wen & dram_hit. dram_addr = perip_addr[DRAM_AW+1:2] - DRAM_BASE word offset.
// - SW/KEY: 2-flop synchronisers, reset to 0. Reads are zero-extended and show the 2-cycle-delayed input.
// - Timer: prescaler counts 0..TICK_DIV-1 while run=1; count+1 on the terminal prescale. Count wraps 0xFFFF_FFFF -> 0.
//   run=0: prescaler held at 0, count frozen.
//   Ctrl write with clear=1: prescaler and count -> 0 at that edge, overriding a same-cycle tick; run takes the written bit.
// - Seg scan: divider 0..SCAN_DIV-1; digit index 0..7 advances on the terminal count and wraps 7 -> 0.
//   seg_an_o = ~(1<<idx). seg_cx_o = hex7(SEG[4*idx+3:4*idx]) with dp off.
//   Outputs registered, one cycle after index/SEG change.
// - Reset values: led_o=0, SEG=0, count=0, run=0, dividers=0, idx=0, seg_an_o=8'hFE, seg_cx_o=8'hC0.
// - Reset asserted mid-operation: everything returns to reset values on that edge, and a write pending in the same cycle is discarded. dram_wen is forced 0 while cpu_rst=1.
// STRUCTURE
// - Package perip_pkg: address constants, CNT ctrl bit positions, hex7 segment table.
// - Sub-module seg7_scan: divider, digit index, an/cx output registers; input = SEG word.
// - Top holds the decoder, read mux, LED/SEG/timer registers and synchronisers.
// TESTING
// 1 DRAM: write 0x8010_0004 <- 0xDEAD_BEEF -> dram_wen=1 with dram_addr=1 that cycle; next-cycle read with dram_rdata model = 0xDEAD_BEEF.
// 2 LED/unmapped: write LED 0x00A5_5A5A -> led_o=0x00A5_5A5A next cycle; read 0x8030_0000 -> 0; write there changes nothing.
// 3 Timer, TICK_DIV=4: write CNT=1 -> count=3 after 12 cycles; write 0 -> frozen; write 3 on tick edge -> count=0 then resumes.
// 4 Wrap: force count=0xFFFF_FFFF, run, one tick -> 0.
// 5 Seg, SCAN_DIV=2, SEG=0x1234_5678 -> an steps FE,FD,..,7F,FE every 2 cycles; cx at idx0 = hex7(8)=0x80.
// 6 sw_i=0x123456 -> SW read 0 for 2 cycles then 0x0012_3456; assert cpu_rst mid-run -> all outputs at reset values next edge.

Source files
------------

// File: rtl/perip_pkg.sv
// Shared constants for the perip_* responder: MMIO register addresses,
// timer control bit positions, decode selector type and the hex digit table.
package perip_pkg;

  localparam logic [31:0] SW_ADDR  = 32'h8020_0000;
  localparam logic [31:0] KEY_ADDR = 32'h8020_0010;
  localparam logic [31:0] SEG_ADDR = 32'h8020_0020;
  localparam logic [31:0] LED_ADDR = 32'h8020_0040;
  localparam logic [31:0] CNT_ADDR = 32'h8020_0050;

  localparam int CNT_RUN_BIT = 0;
  localparam int CNT_CLR_BIT = 1;

  typedef enum logic [2:0] {
    SEL_NONE = 3'd0,
    SEL_DRAM = 3'd1,
    SEL_SW   = 3'd2,
    SEL_KEY  = 3'd3,
    SEL_SEG  = 3'd4,
    SEL_LED  = 3'd5,
    SEL_CNT  = 3'd6
  } sel_e;

  // Active-low segments {dp,g,f,e,d,c,b,a}; dp is always off.
  function automatic logic [7:0] hex7(input logic [3:0] nib);
    logic [7:0] cx;
    case (nib)
      4'h0:    cx = 8'hC0;
      4'h1:    cx = 8'hF9;
      4'h2:    cx = 8'hA4;
      4'h3:    cx = 8'hB0;
      4'h4:    cx = 8'h99;
      4'h5:    cx = 8'h92;
      4'h6:    cx = 8'h82;
      4'h7:    cx = 8'hF8;
      4'h8:    cx = 8'h80;
      4'h9:    cx = 8'h90;
      4'hA:    cx = 8'h88;
      4'hB:    cx = 8'h83;
      4'hC:    cx = 8'hC6;
      4'hD:    cx = 8'hA1;
      4'hE:    cx = 8'h86;
      default: cx = 8'h8E;
    endcase
    return cx;
  endfunction

endpackage

// File: rtl/perip_bridge_seg7_scan.sv
// Seven-segment multiplexer: steps through the eight nibbles of the SEG word
// and drives registered, active-low digit enables and segment patterns.
module seg7_scan
  import perip_pkg::*;
#(
  parameter int SCAN_DIV = 1024
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] seg_i,
  output logic [7:0]  an_o,
  output logic [7:0]  cx_o
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [DW-1:0] div_q, div_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    an_q, an_d;
  logic [7:0]    cx_q, cx_d;
  logic          term_s;

  // Divider, digit index and the decoded pattern for the current digit.
  always_comb begin
    term_s = (div_q == DW'(SCAN_DIV - 1));
    div_d  = term_s ? '0 : div_q + DW'(1);
    idx_d  = term_s ? idx_q + 3'd1 : idx_q;
    an_d   = ~(8'd1 << idx_q);
    cx_d   = hex7(seg_i[{idx_q, 2'b00} +: 4]);
  end

  // Scan state and output registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      div_q <= '0;
      idx_q <= 3'd0;
      an_q  <= 8'hFE;
      cx_q  <= 8'hC0;
    end else begin
      div_q <= div_d;
      idx_q <= idx_d;
      an_q  <= an_d;
      cx_q  <= cx_d;
    end
  end

  assign an_o = an_q;
  assign cx_o = cx_q;

endmodule

// File: rtl/perip_bridge.sv
// Responder end of the myCPU perip_* bus: DRAM window pass-through plus the
// board MMIO registers (switches, keys, seven-segment, LEDs, cycle timer).
module perip_bridge
  import perip_pkg::*;
#(
  parameter logic [31:0] DRAM_BASE = 32'h8010_0000,
  parameter int          DRAM_AW   = 16,
  parameter int          TICK_DIV  = 50_000,
  parameter int          SCAN_DIV  = 1024
) (
  input  logic               cpu_clk,
  input  logic               cpu_rst,
  input  logic [31:0]        perip_addr,
  input  logic               perip_wen,
  input  logic [1:0]         perip_mask,
  input  logic [31:0]        perip_wdata,
  output logic [31:0]        perip_rdata,
  output logic [DRAM_AW-1:0] dram_addr,
  output logic               dram_wen,
  output logic [31:0]        dram_wdata,
  input  logic [31:0]        dram_rdata,
  input  logic [23:0]        sw_i,
  input  logic [4:0]         key_i,
  output logic [23:0]        led_o,
  output logic [7:0]         seg_an_o,
  output logic [7:0]         seg_cx_o
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [31:0]   off_s;
  logic          dram_hit_s;
  sel_e          sel_s;
  logic          cnt_wr_s;
  logic          tick_s;

  logic [23:0]   led_q, led_d;
  logic [31:0]   seg_q, seg_d;
  logic          run_q, run_d;
  logic [TW-1:0] presc_q, presc_d;
  logic [31:0]   cnt_q, cnt_d;
  logic [23:0]   sw_q1, sw_q2;
  logic [4:0]    key_q1, key_q2;

  // The write data arrives pre-merged, so the size field carries no enables.
  logic          unused_s;
  assign unused_s = &{1'b0, perip_mask, off_s};

  // Address decode; byte-lane bits are ignored for register selection.
  always_comb begin
    off_s      = perip_addr - DRAM_BASE;
    dram_hit_s = (perip_addr >= DRAM_BASE) && ((off_s >> (DRAM_AW + 2)) == 32'd0);
    if (dram_hit_s) begin
      sel_s = SEL_DRAM;
    end else begin
      case (perip_addr[31:2])
        SW_ADDR[31:2]:  sel_s = SEL_SW;
        KEY_ADDR[31:2]: sel_s = SEL_KEY;
        SEG_ADDR[31:2]: sel_s = SEL_SEG;
        LED_ADDR[31:2]: sel_s = SEL_LED;
        CNT_ADDR[31:2]: sel_s = SEL_CNT;
        default:        sel_s = SEL_NONE;
      endcase
    end
  end

  // Read mux stays live during writes so the CPU can merge with the old word.
  always_comb begin
    case (sel_s)
      SEL_DRAM: perip_rdata = dram_rdata;
      SEL_SW:   perip_rdata = {8'd0, sw_q2};
      SEL_KEY:  perip_rdata = {27'd0, key_q2};
      SEL_SEG:  perip_rdata = seg_q;
      SEL_LED:  perip_rdata = {8'd0, led_q};
      SEL_CNT:  perip_rdata = cnt_q;
      default:  perip_rdata = 32'd0;
    endcase
  end

  assign dram_addr  = off_s[DRAM_AW+1:2];
  assign dram_wen   = perip_wen & dram_hit_s & ~cpu_rst;
  assign dram_wdata = perip_wdata;

  // Register writes and the timer; a clear write beats a same-edge tick.
  always_comb begin
    led_d    = (perip_wen && (sel_s == SEL_LED)) ? perip_wdata[23:0] : led_q;
    seg_d    = (perip_wen && (sel_s == SEL_SEG)) ? perip_wdata : seg_q;
    cnt_wr_s = perip_wen && (sel_s == SEL_CNT);
    tick_s   = run_q && (presc_q == TW'(TICK_DIV - 1));
    if (!run_q) begin
      presc_d = '0;
      cnt_d   = cnt_q;
    end else if (tick_s) begin
      presc_d = '0;
      cnt_d   = cnt_q + 32'd1;
    end else begin
      presc_d = presc_q + TW'(1);
      cnt_d   = cnt_q;
    end
    if (cnt_wr_s) begin
      run_d   = perip_wdata[CNT_RUN_BIT];
      presc_d = (perip_wdata[CNT_CLR_BIT] || !perip_wdata[CNT_RUN_BIT]) ? '0 : presc_d;
      cnt_d   = perip_wdata[CNT_CLR_BIT] ? 32'd0 : cnt_d;
    end else begin
      run_d = run_q;
    end
  end

  // State registers and input synchronisers.
  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      led_q   <= 24'd0;
      seg_q   <= 32'd0;
      run_q   <= 1'b0;
      presc_q <= '0;
      cnt_q   <= 32'd0;
      sw_q1   <= 24'd0;
      sw_q2   <= 24'd0;
      key_q1  <= 5'd0;
      key_q2  <= 5'd0;
    end else begin
      led_q   <= led_d;
      seg_q   <= seg_d;
      run_q   <= run_d;
      presc_q <= presc_d;
      cnt_q   <= cnt_d;
      sw_q1   <= sw_i;
      sw_q2   <= sw_q1;
      key_q1  <= key_i;
      key_q2  <= key_q1;
    end
  end

  assign led_o = led_q;

  seg7_scan #(
    .SCAN_DIV (SCAN_DIV)
  ) u_scan (
    .clk_i (cpu_clk),
    .rst_i (cpu_rst),
    .seg_i (seg_q),
    .an_o  (seg_an_o),
    .cx_o  (seg_cx_o)
  );

endmodule

// File: tb/tb_perip_bridge.sv
// Directed self-checking bench for perip_bridge with short timer/scan dividers
// and a behavioural DRAM behind the dram_* port.
module tb_perip_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] addr = 32'd0;
  logic        wen = 1'b0;
  logic [1:0]  mask = 2'b11;
  logic [31:0] wdata = 32'd0;
  logic [31:0] rdata;
  logic [15:0] dram_addr;
  logic        dram_wen;
  logic [31:0] dram_wdata;
  logic [31:0] dram_rdata;
  logic [23:0] sw = 24'd0;
  logic [4:0]  key = 5'd0;
  logic [23:0] led;
  logic [7:0]  an, cx;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] mem [0:65535];

  always #5 clk = ~clk;

  always @(posedge clk) if (dram_wen) mem[dram_addr] <= dram_wdata;
  assign dram_rdata = mem[dram_addr];

  perip_bridge #(
    .DRAM_BASE (32'h8010_0000),
    .DRAM_AW   (16),
    .TICK_DIV  (4),
    .SCAN_DIV  (2)
  ) dut (
    .cpu_clk     (clk),
    .cpu_rst     (rst),
    .perip_addr  (addr),
    .perip_wen   (wen),
    .perip_mask  (mask),
    .perip_wdata (wdata),
    .perip_rdata (rdata),
    .dram_addr   (dram_addr),
    .dram_wen    (dram_wen),
    .dram_wdata  (dram_wdata),
    .dram_rdata  (dram_rdata),
    .sw_i        (sw),
    .key_i       (key),
    .led_o       (led),
    .seg_an_o    (an),
    .seg_cx_o    (cx)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    addr = a; wen = 1'b1; wdata = d;
    step();
    wen = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    addr = a; wen = 1'b0;
    #1;
    d = rdata;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    rst = 1'b1; addr = 32'h8010_0000; wen = 1'b1; wdata = 32'h1111_2222;
    repeat (3) step();
    n_checks++; if (dram_wen !== 1'b0) begin n_fail++; $display("FAIL reset_dram_wen: got %b want 0", dram_wen); end
    rst = 1'b0; wen = 1'b0;
    n_checks++; if (led !== 24'd0) begin n_fail++; $display("FAIL reset_led: got %h want 000000", led); end
    n_checks++; if (an !== 8'hFE) begin n_fail++; $display("FAIL reset_an: got %h want fe", an); end
    n_checks++; if (cx !== 8'hC0) begin n_fail++; $display("FAIL reset_cx: got %h want c0", cx); end
    rd(32'h8020_0020, d);
    n_checks++; if (d !== 32'd0) begin n_fail++; $display("FAIL reset_seg: got %h want 0", d); end
    rd(32'h8020_0050, d);
    n_checks++; if (d !== 32'd0) begin n_fail++; $display("FAIL reset_cnt: got %h want 0", d); end
  endtask

  task automatic test_dram();
    logic [31:0] d;
    addr = 32'h8010_0004; wen = 1'b1; wdata = 32'hDEAD_BEEF;
    #1;
    n_checks++; if (dram_wen !== 1'b1) begin n_fail++; $display("FAIL dram_wen: got %b want 1", dram_wen); end
    n_checks++; if (dram_addr !== 16'd1) begin n_fail++; $display("FAIL dram_addr: got %h want 0001", dram_addr); end
    n_checks++; if (dram_wdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL dram_wdata: got %h want deadbeef", dram_wdata); end
    step(); wen = 1'b0;
    rd(32'h8010_0004, d);
    n_checks++; if (d !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL dram_read: got %h want deadbeef", d); end
    addr = 32'h8013_FFFC; wen = 1'b1; wdata = 32'h0BAD_F00D;
    #1;
    n_checks++; if (dram_addr !== 16'hFFFF) begin n_fail++; $display("FAIL dram_top_addr: got %h want ffff", dram_addr); end
    step(); wen = 1'b0;
    rd(32'h8013_FFFE, d);
    n_checks++; if (d !== 32'h0BAD_F00D) begin n_fail++; $display("FAIL dram_top_read: got %h want 0badf00d", d); end
    addr = 32'h800F_FFFC; wen = 1'b1;
    #1;
    n_checks++; if (dram_wen !== 1'b0) begin n_fail++; $display("FAIL dram_below_wen: got %b want 0", dram_wen); end
    n_checks++; if (rdata !== 32'd0) begin n_fail++; $display("FAIL dram_below_read: got %h want 0", rdata); end
    addr = 32'h8014_0000;
    #1;
    n_checks++; if (dram_wen !== 1'b0) begin n_fail++; $display("FAIL dram_above_wen: got %b want 0", dram_wen); end
    n_checks++; if (rdata !== 32'd0) begin n_fail++; $display("FAIL dram_above_read: got %h want 0", rdata); end
    wen = 1'b0;
    step();
  endtask

  task automatic test_led_unmapped();
    logic [31:0] d;
    wr(32'h8020_0040, 32'h00A5_5A5A);
    n_checks++; if (led !== 24'hA5_5A5A) begin n_fail++; $display("FAIL led_write: got %h want a55a5a", led); end
    rd(32'h8020_0043, d);
    n_checks++; if (d !== 32'h00A5_5A5A) begin n_fail++; $display("FAIL led_read_offset: got %h want 00a55a5a", d); end
    rd(32'h8030_0000, d);
    n_checks++; if (d !== 32'd0) begin n_fail++; $display("FAIL unmapped_read: got %h want 0", d); end
    wr(32'h8030_0000, 32'hFFFF_FFFF);
    wr(32'h8020_0000, 32'hFFFF_FFFF);
    n_checks++; if (led !== 24'hA5_5A5A) begin n_fail++; $display("FAIL unmapped_led: got %h want a55a5a", led); end
    rd(32'h8030_0000, d);
    n_checks++; if (d !== 32'd0) begin n_fail++; $display("FAIL unmapped_read2: got %h want 0", d); end
    rd(32'h8020_0020, d);
    n_checks++; if (d !== 32'd0) begin n_fail++; $display("FAIL unmapped_seg: got %h want 0", d); end
    rd(32'h8020_0000, d);
    n_checks++; if (d !== 32'd0) begin n_fail++; $display("FAIL sw_readonly: got %h want 0", d); end
  endtask

  task automatic test_timer();
    logic [31:0] d;
    wr(32'h8020_0050, 32'd1);
    repeat (11) step();
    rd(32'h8020_0050, d);
    n_checks++; if (d !== 32'd2) begin n_fail++; $display("FAIL timer_11: got %0d want 2", d); end
    step();
    rd(32'h8020_0050, d);
    n_checks++; if (d !== 32'd3) begin n_fail++; $display("FAIL timer_12: got %0d want 3", d); end
    wr(32'h8020_0050, 32'd0);
    repeat (8) step();
    rd(32'h8020_0050, d);
    n_checks++; if (d !== 32'd3) begin n_fail++; $display("FAIL timer_frozen: got %0d want 3", d); end
    wr(32'h8020_0050, 32'd1);
    repeat (3) step();
    rd(32'h8020_0050, d);
    n_checks++; if (d !== 32'd3) begin n_fail++; $display("FAIL timer_pre_tick: got %0d want 3", d); end
    wr(32'h8020_0050, 32'd3);
    rd(32'h8020_0050, d);
    n_checks++; if (d !== 32'd0) begin n_fail++; $display("FAIL timer_clear_on_tick: got %0d want 0", d); end
    repeat (3) step();
    rd(32'h8020_0050, d);
    n_checks++; if (d !== 32'd0) begin n_fail++; $display("FAIL timer_after_clear3: got %0d want 0", d); end
    step();
    rd(32'h8020_0050, d);
    n_checks++; if (d !== 32'd1) begin n_fail++; $display("FAIL timer_resume: got %0d want 1", d); end
  endtask

  task automatic test_wrap();
    logic [31:0] d;
    wr(32'h8020_0050, 32'd2);
    force dut.cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.cnt_q;
    rd(32'h8020_0050, d);
    n_checks++; if (d !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL wrap_preload: got %h want ffffffff", d); end
    wr(32'h8020_0050, 32'd1);
    repeat (3) step();
    rd(32'h8020_0050, d);
    n_checks++; if (d !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL wrap_before: got %h want ffffffff", d); end
    step();
    rd(32'h8020_0050, d);
    n_checks++; if (d !== 32'd0) begin n_fail++; $display("FAIL wrap_after: got %h want 0", d); end
    wr(32'h8020_0050, 32'd0);
  endtask

  task automatic test_seg();
    logic [31:0] d;
    logic [7:0]  prev;
    logic [7:0]  exp_an;
    logic [7:0]  exp_cx [8];
    bit          found;
    // hex7 of nibbles 8,7,6,5,4,3,2,1 for digits 0..7 of 0x1234_5678
    exp_cx = '{8'h80, 8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9};
    wr(32'h8020_0020, 32'h1234_5678);
    rd(32'h8020_0020, d);
    n_checks++; if (d !== 32'h1234_5678) begin n_fail++; $display("FAIL seg_read: got %h want 12345678", d); end
    step();
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      prev = an;
      step();
      if (an == 8'hFE && prev != 8'hFE) found = 1'b1;
    end
    n_checks++; if (!found) begin n_fail++; $display("FAIL seg_sync: got no fe step want fe within 40 cycles"); end
    for (int k = 0; k < 9; k++) begin
      exp_an = ~(8'd1 << (k % 8));
      for (int h = 0; h < 2; h++) begin
        n_checks++; if (an !== exp_an) begin n_fail++; $display("FAIL seg_an k=%0d h=%0d: got %h want %h", k, h, an, exp_an); end
        n_checks++; if (cx !== exp_cx[k % 8]) begin n_fail++; $display("FAIL seg_cx k=%0d h=%0d: got %h want %h", k, h, cx, exp_cx[k % 8]); end
        step();
      end
    end
  endtask

  task automatic test_sync();
    logic [31:0] d;
    sw = 24'h12_3456; key = 5'h15;
    rd(32'h8020_0000, d);
    n_checks++; if (d !== 32'd0) begin n_fail++; $display("FAIL sw_cycle0: got %h want 0", d); end
    step();
    rd(32'h8020_0000, d);
    n_checks++; if (d !== 32'd0) begin n_fail++; $display("FAIL sw_cycle1: got %h want 0", d); end
    step();
    rd(32'h8020_0000, d);
    n_checks++; if (d !== 32'h0012_3456) begin n_fail++; $display("FAIL sw_cycle2: got %h want 00123456", d); end
    rd(32'h8020_0010, d);
    n_checks++; if (d !== 32'h0000_0015) begin n_fail++; $display("FAIL key_read: got %h want 00000015", d); end
  endtask

  task automatic test_rst_mid();
    logic [31:0] d;
    wr(32'h8020_0050, 32'd1);
    repeat (6) step();
    rst = 1'b1; addr = 32'h8010_0008; wen = 1'b1; wdata = 32'h5555_AAAA;
    #1;
    n_checks++; if (dram_wen !== 1'b0) begin n_fail++; $display("FAIL rst_dram_wen: got %b want 0", dram_wen); end
    addr = 32'h8020_0040; wdata = 32'h00FF_FFFF;
    step();
    rst = 1'b0; wen = 1'b0;
    n_checks++; if (led !== 24'd0) begin n_fail++; $display("FAIL rst_led: got %h want 000000", led); end
    n_checks++; if (an !== 8'hFE) begin n_fail++; $display("FAIL rst_an: got %h want fe", an); end
    n_checks++; if (cx !== 8'hC0) begin n_fail++; $display("FAIL rst_cx: got %h want c0", cx); end
    rd(32'h8020_0050, d);
    n_checks++; if (d !== 32'd0) begin n_fail++; $display("FAIL rst_cnt: got %h want 0", d); end
    rd(32'h8020_0020, d);
    n_checks++; if (d !== 32'd0) begin n_fail++; $display("FAIL rst_seg: got %h want 0", d); end
    rd(32'h8020_0000, d);
    n_checks++; if (d !== 32'd0) begin n_fail++; $display("FAIL rst_sw: got %h want 0", d); end
    repeat (8) step();
    rd(32'h8020_0050, d);
    n_checks++; if (d !== 32'd0) begin n_fail++; $display("FAIL rst_cnt_stopped: got %h want 0", d); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 32'd0;
    #1;
    test_reset();
    test_dram();
    test_led_unmapped();
    test_timer();
    test_wrap();
    test_seg();
    test_sync();
    test_rst_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
